hazard_scoreboard: RTL and testbench
====================================

Name: hazard_scoreboard

Overview:
- Parametrised hazard/forwarding unit for the ARM pipeline. It drives the freeze/hazard net into the IF stage, the IF/ID register and the ID stage.
- Tracks in-flight destinations through a DEPTH-entry shift chain that mirrors the post-ID stages (EXE, MEM, WB by default).
- Compares the ID-stage sources against the chain and produces a stall, per-operand forwarding selects and a stall counter.
- Runtime mode selects stall-only operation or forwarding with load-use stall.

Parameters:
- DEPTH, 3, number of post-ID pipeline stages tracked; entry 0 = EXE, entry DEPTH-1 = WB.
- REG_AW, 4, register-address width.
- WB_BYPASS, 1, when 1 the regfile is write-before-read, so entry DEPTH-1 is ignored for hazards and forwarding.
- CNT_W, 16, stall counter width.
- SEL_W, $clog2(DEPTH+1), forwarding select width.

Ports:
- clk  in  1  clock, rising edge.
- rst  in  1  asynchronous, active-high reset.
- id_valid  in  1  ID holds a real instruction.
- src1  in  REG_AW  Rn of ID instruction.
- src1_used  in  1  instruction reads Rn.
- src2  in  REG_AW  Rm/Rd source of ID instruction.
- two_src  in  1  instruction reads src2.
- id_dest  in  REG_AW  destination of ID instruction.
- id_wb_en  in  1  ID instruction writes back.
- id_mem_read  in  1  ID instruction is a load.
- flush  in  1  branch taken in EXE; squash ID.
- forward_en  in  1  0 = stall-only mode, 1 = forwarding mode.
- hazard  out  1  freeze IF, IF/ID and ID; bubble into ID/EX.
- fwd_sel_a  out  SEL_W  0 = regfile; k+1 = take operand A from entry k.
- fwd_sel_b  out  SEL_W  as above, for operand B.
- pending_mask  out  DEPTH  bit k = entry k valid and wb_en.
- stall_count  out  CNT_W  saturating count of stall cycles.

Behaviour:
- Entry fields: valid, dest, wb_en, mem_read.
- Each rising edge, entries shift k -> k+1 and entry DEPTH-1 is discarded.
- Entry 0 load value:
  - bubble (all fields 0) if flush, or hazard, or !id_valid;
  - otherwise {1, id_dest, id_wb_en, id_mem_read}.
- Match rule: entry k matches a source s when valid && wb_en && dest==s, and k is not excluded (k=DEPTH-1 is excluded when WB_BYPASS=1).
- A source is active only when id_valid, and for src1 also src1_used, and for src2 also two_src.
- forward_en=0:
  - hazard = any active source matches any entry.
  - fwd_sel_a = fwd_sel_b = 0.
- forward_en=1:
  - hazard = an active source matches entry 0 and entry 0 has mem_read (load-use).
  - Otherwise fwd_sel = k+1 for the lowest-index matching entry, so the youngest producer wins; 0 if no match or the source is inactive.
  - While hazard=1, fwd_sel outputs are still driven; the consumer ignores them.
- flush has priority: hazard is forced to 0 while flush=1, and the ID instruction is dropped.
- stall_count increments on every edge where hazard=1 and saturates at all-ones.
- hazard, fwd_sel and pending_mask are combinational from the entries and inputs; there is no added latency.
- A stalled instruction re-evaluates each cycle. The stall lasts until the producer passes the last stage that blocks it:
  - stall-only, DEPTH=3, WB_BYPASS=1: 2 cycles behind an EXE producer;
  - forwarding: 1 cycle for load-use.
- Reset: all entries invalid, stall_count=0, hazard=0, fwd_sel_a=fwd_sel_b=0, pending_mask=0. A reset asserted mid-stall clears everything immediately, asynchronously.
- Register R0 is an ordinary register, with no special zero handling.
- Simultaneous flush and hazard: the bubble is inserted, hazard=0 and stall_count is not incremented.
- A mode change on forward_en takes effect combinationally in the same cycle; chain contents are unaffected.

Test Plan:
- Reset, then ADD R1 (wb) followed by SUB using src1=R1, forward_en=0 -> hazard=1 for exactly 2 cycles, stall_count=2, then hazard=0 with fwd_sel_a=0.
- Same sequence with forward_en=1 -> hazard never asserts; fwd_sel_a=1 on the dependent cycle. With one independent instruction in between -> fwd_sel_a=2.
- LDR R2 then ADD src2=R2, two_src=1, forward_en=1 -> hazard=1 for 1 cycle, then fwd_sel_b=2, stall_count=1.
- Writes to R3 from entries 0 and 1 (two back-to-back producers), consumer src1=R3 -> fwd_sel_a=1 (youngest wins).
- Hazard pending on R4 with flush=1 in the same cycle -> hazard=0, entry 0 is a bubble, pending_mask bit0=0, stall_count unchanged.
- Hold a dependency with forward_en=0 and CNT_W=2, forcing a long stall through producer re-issue -> stall_count saturates at 3. Assert rst mid-stall -> all outputs 0 immediately.

Source files
------------

// File: rtl/hazard_scoreboard.sv
// rtl/hazard_scoreboard.sv - in-flight destination chain producing stall, forwarding selects and stall count
// Entry 0 mirrors EXE, entry DEPTH-1 mirrors WB; entries shift every cycle.
module hazard_scoreboard #(
  parameter int DEPTH     = 3,
  parameter int REG_AW    = 4,
  parameter int WB_BYPASS = 1,
  parameter int CNT_W     = 16,
  parameter int SEL_W     = $clog2(DEPTH + 1)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              id_valid,
  input  logic [REG_AW-1:0] src1,
  input  logic              src1_used,
  input  logic [REG_AW-1:0] src2,
  input  logic              two_src,
  input  logic [REG_AW-1:0] id_dest,
  input  logic              id_wb_en,
  input  logic              id_mem_read,
  input  logic              flush,
  input  logic              forward_en,
  output logic              hazard,
  output logic [SEL_W-1:0]  fwd_sel_a,
  output logic [SEL_W-1:0]  fwd_sel_b,
  output logic [DEPTH-1:0]  pending_mask,
  output logic [CNT_W-1:0]  stall_count
);

  logic [DEPTH-1:0]             valid_q, valid_d;
  logic [DEPTH-1:0]             wb_q, wb_d;
  logic [DEPTH-1:0]             mr_q, mr_d;
  logic [DEPTH-1:0][REG_AW-1:0] dest_q, dest_d;
  logic [CNT_W-1:0]             cnt_q, cnt_d;

  logic [DEPTH-1:0] live;
  logic [DEPTH-1:0] match1;
  logic [DEPTH-1:0] match2;
  logic             act1;
  logic             act2;
  logic             hazard_raw;
  logic             load0;

  always_comb begin
    act1       = id_valid & src1_used;
    act2       = id_valid & two_src;
    live       = '0;
    match1     = '0;
    match2     = '0;
    fwd_sel_a  = '0;
    fwd_sel_b  = '0;
    for (int k = 0; k < DEPTH; k++) begin
      // With a write-before-read regfile the WB entry is already visible to ID.
      live[k]   = valid_q[k] & wb_q[k] & ~((WB_BYPASS != 0) && (k == DEPTH - 1));
      match1[k] = act1 & live[k] & (dest_q[k] == src1);
      match2[k] = act2 & live[k] & (dest_q[k] == src2);
    end
    if (forward_en) begin
      hazard_raw = (match1[0] | match2[0]) & mr_q[0];
    end else begin
      hazard_raw = |(match1 | match2);
    end
    hazard = hazard_raw & ~flush;
    if (forward_en) begin
      // Scan oldest to youngest so the youngest producer overwrites.
      for (int k = DEPTH - 1; k >= 0; k--) begin
        if (match1[k]) fwd_sel_a = SEL_W'(k + 1);
        if (match2[k]) fwd_sel_b = SEL_W'(k + 1);
      end
    end
    pending_mask = valid_q & wb_q;
    stall_count  = cnt_q;
  end

  always_comb begin
    load0     = id_valid & ~flush & ~hazard;
    valid_d   = '0;
    wb_d      = '0;
    mr_d      = '0;
    dest_d    = '0;
    valid_d[0] = load0;
    wb_d[0]    = load0 & id_wb_en;
    mr_d[0]    = load0 & id_mem_read;
    dest_d[0]  = load0 ? id_dest : '0;
    for (int k = 1; k < DEPTH; k++) begin
      valid_d[k] = valid_q[k-1];
      wb_d[k]    = wb_q[k-1];
      mr_d[k]    = mr_q[k-1];
      dest_d[k]  = dest_q[k-1];
    end
    cnt_d = cnt_q;
    if (hazard && (cnt_q != '1)) cnt_d = cnt_q + CNT_W'(1);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      valid_q <= '0;
      wb_q    <= '0;
      mr_q    <= '0;
      dest_q  <= '0;
      cnt_q   <= '0;
    end else begin
      valid_q <= valid_d;
      wb_q    <= wb_d;
      mr_q    <= mr_d;
      dest_q  <= dest_d;
      cnt_q   <= cnt_d;
    end
  end

endmodule

// File: tb/tb_hazard_scoreboard.sv
// tb/tb_hazard_scoreboard.sv - directed and random checks of hazard_scoreboard against an issue-history model
module tb_hazard_scoreboard;

  localparam int DEPTH = 3;
  localparam int LIVE  = 2;
  localparam int AW    = 4;

  logic          clk = 1'b0;
  logic          rst;
  logic          id_valid, src1_used, two_src, id_wb_en, id_mem_read, flush, forward_en;
  logic [AW-1:0] src1, src2, id_dest;
  logic          hazard, hazard2;
  logic [1:0]    fwd_sel_a, fwd_sel_b, fwd_sel_a2, fwd_sel_b2;
  logic [2:0]    pending_mask, pending_mask2;
  logic [15:0]   stall_count;
  logic [1:0]    stall_count2;

  always #5 clk = ~clk;

  hazard_scoreboard #(.DEPTH(3), .REG_AW(4), .WB_BYPASS(1), .CNT_W(16)) dut (
    .clk(clk), .rst(rst), .id_valid(id_valid), .src1(src1), .src1_used(src1_used),
    .src2(src2), .two_src(two_src), .id_dest(id_dest), .id_wb_en(id_wb_en),
    .id_mem_read(id_mem_read), .flush(flush), .forward_en(forward_en),
    .hazard(hazard), .fwd_sel_a(fwd_sel_a), .fwd_sel_b(fwd_sel_b),
    .pending_mask(pending_mask), .stall_count(stall_count));

  hazard_scoreboard #(.DEPTH(3), .REG_AW(4), .WB_BYPASS(1), .CNT_W(2)) dut2 (
    .clk(clk), .rst(rst), .id_valid(id_valid), .src1(src1), .src1_used(src1_used),
    .src2(src2), .two_src(two_src), .id_dest(id_dest), .id_wb_en(id_wb_en),
    .id_mem_read(id_mem_read), .flush(flush), .forward_en(forward_en),
    .hazard(hazard2), .fwd_sel_a(fwd_sel_a2), .fwd_sel_b(fwd_sel_b2),
    .pending_mask(pending_mask2), .stall_count(stall_count2));

  typedef struct {
    logic [AW-1:0] dest;
    bit            wb;
    bit            mr;
    int            issue;
  } rec_t;

  rec_t q[$];
  int   cyc = 0;
  int   exp_cnt = 0;
  int   exp_cnt2 = 0;
  int   checks = 0;
  int   errors = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  // Producers are kept as an issue history; position in the pipeline is the age since issue.
  task automatic model_eval(output bit hz, output int sa, output int sb, output logic [2:0] pm);
    int  y1 = -1;
    int  y2 = -1;
    bit  ld0 = 0;
    pm = '0;
    foreach (q[i]) begin
      int age = cyc - q[i].issue - 1;
      if (age < 0 || age >= DEPTH || !q[i].wb) continue;
      pm[age] = 1'b1;
      if (age < LIVE) begin
        if (id_valid && src1_used && q[i].dest == src1 && (y1 < 0 || age < y1)) y1 = age;
        if (id_valid && two_src && q[i].dest == src2 && (y2 < 0 || age < y2)) y2 = age;
        if (age == 0) ld0 = q[i].mr;
      end
    end
    if (forward_en) begin
      hz = (y1 == 0 || y2 == 0) && ld0;
      sa = y1 + 1;
      sb = y2 + 1;
    end else begin
      hz = (y1 >= 0 || y2 >= 0);
      sa = 0;
      sb = 0;
    end
    hz = hz && !flush;
  endtask

  task automatic do_cycle(output bit hz);
    int         sa, sb;
    logic [2:0] pm;
    #2;
    model_eval(hz, sa, sb, pm);
    chk("hazard", hazard, hz);
    chk("fwd_sel_a", fwd_sel_a, sa);
    chk("fwd_sel_b", fwd_sel_b, sb);
    chk("pending_mask", pending_mask, pm);
    chk("stall_count", stall_count, exp_cnt);
    chk("stall_count_w2", stall_count2, exp_cnt2);
    @(posedge clk);
    if (hz) begin
      if (exp_cnt < 65535) exp_cnt++;
      if (exp_cnt2 < 3) exp_cnt2++;
    end
    if (id_valid && !flush && !hz) q.push_back('{id_dest, id_wb_en, id_mem_read, cyc});
    cyc++;
    while (q.size() > 0 && cyc - q[0].issue - 1 >= DEPTH) void'(q.pop_front());
    #1;
  endtask

  task automatic drive(input bit v, input int s1, input bit u1, input int s2, input bit two,
                       input int d, input bit wb, input bit mr);
    id_valid = v; src1 = AW'(s1); src1_used = u1; src2 = AW'(s2); two_src = two;
    id_dest = AW'(d); id_wb_en = wb; id_mem_read = mr;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    q.delete();
    exp_cnt = 0;
    exp_cnt2 = 0;
  endtask

  bit h;

  initial begin
    rst = 1'b1; flush = 0; forward_en = 0;
    drive(0, 0, 0, 0, 0, 0, 0, 0);
    @(posedge clk);
    #1;
    chk("rst_hazard", hazard, 0);
    chk("rst_sel_a", fwd_sel_a, 0);
    chk("rst_sel_b", fwd_sel_b, 0);
    chk("rst_pending", pending_mask, 0);
    chk("rst_count", stall_count, 0);
    rst = 1'b0;

    // Stall-only: ADD R1 then dependent SUB stalls 2 cycles.
    forward_en = 0;
    drive(1, 0, 0, 0, 0, 1, 1, 0); do_cycle(h);
    drive(1, 1, 1, 0, 0, 7, 1, 0);
    #1 chk("so_hz_c1", hazard, 1);
    do_cycle(h);
    do_cycle(h);
    #1 chk("so_hz_c3", hazard, 0);
    do_cycle(h);
    chk("so_cnt", stall_count, 2);

    // Forwarding: back-to-back gives select 1, one instruction apart gives select 2.
    do_reset();
    forward_en = 1;
    drive(1, 0, 0, 0, 0, 1, 1, 0); do_cycle(h);
    drive(1, 1, 1, 0, 0, 7, 1, 0);
    #1 chk("fw_sel1", fwd_sel_a, 1);
    do_cycle(h);
    drive(1, 0, 0, 0, 0, 1, 1, 0); do_cycle(h);
    drive(1, 0, 0, 0, 0, 6, 1, 0); do_cycle(h);
    drive(1, 1, 1, 0, 0, 8, 1, 0);
    #1 chk("fw_sel2", fwd_sel_a, 2);
    do_cycle(h);
    chk("fw_cnt", stall_count, 0);

    // Load-use: one stall cycle, then forward from entry 1.
    do_reset();
    drive(1, 0, 0, 0, 0, 2, 1, 1); do_cycle(h);
    drive(1, 0, 0, 2, 1, 9, 1, 0);
    #1 chk("lu_hz", hazard, 1);
    do_cycle(h);
    #1 chk("lu_sel_b", fwd_sel_b, 2);
    do_cycle(h);
    chk("lu_cnt", stall_count, 1);

    // Two producers of R3: youngest wins.
    do_reset();
    drive(1, 0, 0, 0, 0, 3, 1, 0); do_cycle(h);
    drive(1, 0, 0, 0, 0, 3, 1, 0); do_cycle(h);
    drive(1, 3, 1, 0, 0, 10, 1, 0);
    #1 chk("yw_sel_a", fwd_sel_a, 1);
    do_cycle(h);

    // Flush coincident with a pending hazard on R4.
    do_reset();
    forward_en = 0;
    drive(1, 0, 0, 0, 0, 4, 1, 0); do_cycle(h);
    drive(1, 4, 1, 0, 0, 11, 1, 0); flush = 1;
    #1 chk("fl_hz", hazard, 0);
    do_cycle(h);
    flush = 0;
    drive(0, 0, 0, 0, 0, 0, 0, 0);
    #1 chk("fl_mask", pending_mask, 3'b010);
    chk("fl_cnt", stall_count, 0);
    do_cycle(h);

    // Repeated producer/consumer pairs saturate the 2-bit counter, then reset mid-stall.
    do_reset();
    for (int r = 0; r < 3; r++) begin
      drive(1, 0, 0, 0, 0, 5, 1, 0); do_cycle(h);
      drive(1, 5, 1, 0, 0, 12, 1, 0);
      for (int c = 0; c < 3; c++) do_cycle(h);
    end
    chk("sat_cnt2", stall_count2, 3);
    chk("sat_cnt", stall_count, 6);
    drive(1, 0, 0, 0, 0, 5, 1, 0); do_cycle(h);
    drive(1, 5, 1, 0, 0, 12, 1, 0);
    #2 chk("mid_hz", hazard, 1);
    rst = 1'b1;
    #1;
    chk("arst_hz", hazard, 0);
    chk("arst_sel_a", fwd_sel_a, 0);
    chk("arst_sel_b", fwd_sel_b, 0);
    chk("arst_mask", pending_mask, 0);
    chk("arst_cnt", stall_count, 0);
    chk("arst_cnt2", stall_count2, 0);
    @(posedge clk);
    #1;
    rst = 1'b0;
    q.delete();
    exp_cnt = 0;
    exp_cnt2 = 0;

    // Random traffic with mode changes, flushes, R0 and held stalled instructions.
    h = 0;
    for (int n = 0; n < 400; n++) begin
      if (n % 16 == 0) forward_en = 1'($urandom_range(0, 1));
      flush = ($urandom_range(0, 9) == 0);
      if (!(h && $urandom_range(0, 3) != 0))
        drive($urandom_range(0, 4) != 0, $urandom_range(0, 3), 1'($urandom_range(0, 1)),
              $urandom_range(0, 3), 1'($urandom_range(0, 1)), $urandom_range(0, 3),
              $urandom_range(0, 3) != 0, $urandom_range(0, 2) == 0);
      do_cycle(h);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
